// File: rtl/oddr71_pkg.sv
// Shared types and pattern constants for the 7:1 LVDS transmit sequencer.
package oddr71_pkg;

  typedef enum logic [1:0] {
    ST_RESET_HOLD = 2'd0,
    ST_TRAIN      = 2'd1,
    ST_IDLE       = 2'd2,
    ST_RUN        = 2'd3
  } state_e;

  // Clock lane sends 1100011 LSB-first, giving the 4:3 duty 7:1 pixel clock.
  localparam logic [6:0] CLK_LANE_PATTERN  = 7'b1100011;
  localparam logic [6:0] TRAIN_PATTERN_DEF = 7'b1111000;
  localparam logic [6:0] IDLE_PATTERN_DEF  = 7'b0000000;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (clr_i)                  cnt_q <= '0;
    else if (inc_i && ~&cnt_q)  cnt_q <= cnt_q + W'(1);
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/oddr71_tx_sequencer.sv
// SCLK-domain sequencer for LANES 7:1 gearboxes plus clock lane:
// reset hold, training burst, then valid/ready pixel streaming with idle fill.
module oddr71_tx_sequencer
  import oddr71_pkg::*;
#(
  parameter int         LANES         = 4,
  parameter int         GB_RST_CYCLES = 8,
  parameter int         TRAIN_WORDS   = 64,
  parameter logic [6:0] TRAIN_PATTERN = TRAIN_PATTERN_DEF,
  parameter logic [6:0] IDLE_PATTERN  = IDLE_PATTERN_DEF,
  parameter int         UCNT_W        = 16
) (
  input  logic                sclk,
  input  logic                rstb,
  input  logic                enable,
  input  logic                train_req,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [7*LANES-1:0]  s_data,
  output logic [7*LANES-1:0]  lane_d,
  output logic [6:0]          clk_d,
  output logic                gb_rst,
  output logic                link_up,
  output logic                training,
  output logic [UCNT_W-1:0]   underrun_cnt,
  output logic [1:0]          state_o
);

  localparam logic [7:0]  HOLD_LAST = 8'(GB_RST_CYCLES - 1);
  localparam logic [15:0] WORD_LAST = 16'(TRAIN_WORDS - 1);

  state_e               state_q, state_d;
  logic [7:0]           hold_q, hold_d;
  logic [15:0]          word_q, word_d;
  logic                 xfer;
  logic [7*LANES-1:0]   lane_q;
  logic [6:0]           clk_q;
  logic                 gb_rst_q, link_up_q, training_q;

  // train_req steals the cycle so the pending word stays with the source.
  assign s_ready = (state_q == ST_RUN) && enable && !train_req;
  assign xfer    = s_ready && s_valid;

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    word_d  = word_q;
    case (state_q)
      ST_RESET_HOLD: begin
        if (hold_q == HOLD_LAST) begin
          state_d = enable ? ST_TRAIN : ST_IDLE;
          word_d  = '0;
        end else begin
          hold_d = hold_q + 8'd1;
        end
      end
      ST_TRAIN: begin
        if (!enable)                  state_d = ST_IDLE;
        else if (train_req)           word_d  = '0;
        else if (word_q == WORD_LAST) state_d = ST_RUN;
        else                          word_d  = word_q + 16'd1;
      end
      ST_IDLE: begin
        if (enable) begin
          state_d = ST_TRAIN;
          word_d  = '0;
        end
      end
      ST_RUN: begin
        if (!enable) begin
          state_d = ST_IDLE;
        end else if (train_req) begin
          state_d = ST_TRAIN;
          word_d  = '0;
        end
      end
    endcase
  end

  // Outputs are decoded from the next state so they line up with lane_d.
  always_ff @(posedge sclk) begin
    if (rstb) begin
      state_q    <= ST_RESET_HOLD;
      hold_q     <= '0;
      word_q     <= '0;
      lane_q     <= '0;
      clk_q      <= '0;
      gb_rst_q   <= 1'b1;
      link_up_q  <= 1'b0;
      training_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      word_q     <= word_d;
      gb_rst_q   <= (state_d == ST_RESET_HOLD);
      clk_q      <= (state_d == ST_RESET_HOLD) ? 7'd0 : CLK_LANE_PATTERN;
      link_up_q  <= (state_d == ST_RUN);
      training_q <= (state_d == ST_TRAIN);
      if (xfer)                           lane_q <= s_data;
      else if (state_d == ST_TRAIN)       lane_q <= {LANES{TRAIN_PATTERN}};
      else if (state_d == ST_RESET_HOLD)  lane_q <= '0;
      else                                lane_q <= {LANES{IDLE_PATTERN}};
    end
  end

  sat_counter #(.W(UCNT_W)) u_ucnt (
    .clk_i (sclk),
    .clr_i (rstb),
    .inc_i ((state_q == ST_RUN) && !xfer),
    .cnt_o (underrun_cnt)
  );

  assign lane_d   = lane_q;
  assign clk_d    = clk_q;
  assign gb_rst   = gb_rst_q;
  assign link_up  = link_up_q;
  assign training = training_q;
  assign state_o  = state_q;

endmodule
